// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, stability-confirmed debounce FSM,
// one-cycle press pulse and a saturating count of aborted confirmations.
module btn_debounce_pulse #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8,
  parameter int GL_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_in,
  output logic            x_pulse,
  output logic            level,
  output logic [GL_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONF_HI = 2'd1,
    HIGH    = 2'd2,
    CONF_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [GL_W-1:0]  GL_MAX   = '1;

  state_t           state_q;
  logic             s1_q;
  logic             s_btn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             x_pulse_q;
  logic             level_q;
  logic [GL_W-1:0]  glitch_q;
  logic [GL_W-1:0]  glitch_d;

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_q != GL_MAX) glitch_d = glitch_q + GL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s_btn_q   <= 1'b0;
      cnt_q     <= '0;
      x_pulse_q <= 1'b0;
      level_q   <= 1'b0;
      glitch_q  <= '0;
    end else begin
      s1_q      <= btn_in;
      s_btn_q   <= s1_q;
      x_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_btn_q) begin
            state_q <= CONF_HI;
            cnt_q   <= '0;
          end
        end
        CONF_HI: begin
          if (!s_btn_q) begin
            state_q  <= IDLE;
            glitch_q <= glitch_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= HIGH;
            level_q   <= 1'b1;
            x_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s_btn_q) begin
            state_q <= CONF_LO;
            cnt_q   <= '0;
          end
        end
        CONF_LO: begin
          // a release only drops the level; it never pulses
          if (s_btn_q) begin
            state_q  <= HIGH;
            glitch_q <= glitch_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign x_pulse    = x_pulse_q;
  assign level      = level_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: vector table, corner-case sequences and a random
// run checked against a run-length reference model of the debounce rules.
module tb_btn_debounce_pulse;

  localparam int DB     = 4;
  localparam int GL_MAX = 255;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       x_pulse;
  logic       level;
  logic [7:0] glitch_cnt;

  btn_debounce_pulse #(.DB_CYCLES(DB), .CNT_W(8), .GL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .x_pulse    (x_pulse),
    .level      (level),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int npulse = 0;

  // reference model: synchroniser delay plus run length of samples opposing the level
  logic m_s1, m_sbtn, m_lvl, m_x;
  int   m_run, m_gl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_s1 = 0; m_sbtn = 0; m_lvl = 0; m_x = 0; m_run = 0; m_gl = 0;
  endtask

  task automatic mstep();
    logic sv;
    sv  = m_sbtn;
    m_x = 0;
    if (sv != m_lvl) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_lvl = sv;
        m_run = 0;
        m_x   = sv;
      end
    end else begin
      if (m_run > 0 && m_gl < GL_MAX) m_gl++;
      m_run = 0;
    end
    m_sbtn = m_s1;
    m_s1   = btn_in;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) mreset(); else mstep();
    #1;
    chk("x_pulse", x_pulse, m_x);
    chk("level", level, m_lvl);
    chk("glitch_cnt", glitch_cnt, m_gl);
    if (x_pulse) npulse++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic btn;
    logic exp_x;
    logic exp_level;
  } vec_t;

  vec_t vtab[22];

  initial begin
    int idx;
    int p0;

    // press held 12 edges, then release held 10 edges
    vtab[0]  = '{1'b1, 1'b0, 1'b0};  vtab[1]  = '{1'b1, 1'b0, 1'b0};
    vtab[2]  = '{1'b1, 1'b0, 1'b0};  vtab[3]  = '{1'b1, 1'b0, 1'b0};
    vtab[4]  = '{1'b1, 1'b0, 1'b0};  vtab[5]  = '{1'b1, 1'b0, 1'b0};
    vtab[6]  = '{1'b1, 1'b1, 1'b1};  vtab[7]  = '{1'b1, 1'b0, 1'b1};
    vtab[8]  = '{1'b1, 1'b0, 1'b1};  vtab[9]  = '{1'b1, 1'b0, 1'b1};
    vtab[10] = '{1'b1, 1'b0, 1'b1};  vtab[11] = '{1'b1, 1'b0, 1'b1};
    vtab[12] = '{1'b0, 1'b0, 1'b1};  vtab[13] = '{1'b0, 1'b0, 1'b1};
    vtab[14] = '{1'b0, 1'b0, 1'b1};  vtab[15] = '{1'b0, 1'b0, 1'b1};
    vtab[16] = '{1'b0, 1'b0, 1'b1};  vtab[17] = '{1'b0, 1'b0, 1'b1};
    vtab[18] = '{1'b0, 1'b0, 1'b0};  vtab[19] = '{1'b0, 1'b0, 1'b0};
    vtab[20] = '{1'b0, 1'b0, 1'b0};  vtab[21] = '{1'b0, 1'b0, 1'b0};

    mreset();
    rst = 1'b1;
    btn_in = 1'b0;
    tick();
    tick();
    chk("reset_x_pulse", x_pulse, 0);
    chk("reset_level", level, 0);
    chk("reset_glitch", glitch_cnt, 0);
    rst = 1'b0;

    repeat (20) tick();
    chk("idle_pulses", npulse, 0);
    chk("idle_level", level, 0);

    for (int i = 0; i < 22; i++) begin
      btn_in = vtab[i].btn;
      tick();
      chk($sformatf("vec%0d_x", i), x_pulse, vtab[i].exp_x);
      chk($sformatf("vec%0d_level", i), level, vtab[i].exp_level);
    end

    // bounce: two aborted confirmations, then one pulse 6 edges after steady rise
    do_reset();
    repeat (4) tick();
    p0 = npulse;
    btn_in = 1; repeat (3) tick();
    btn_in = 0; tick();
    btn_in = 1; repeat (3) tick();
    btn_in = 0; tick();
    btn_in = 1;
    idx = -1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (x_pulse && idx < 0) idx = k;
    end
    chk("bounce_pulse_edge", idx, 6);
    chk("bounce_glitches", glitch_cnt, 2);
    chk("bounce_pulse_count", npulse - p0, 1);

    // low glitch while HIGH, then clean release
    p0 = npulse;
    btn_in = 0; repeat (2) tick();
    btn_in = 1; repeat (8) tick();
    chk("rel_glitch_cnt", glitch_cnt, 3);
    chk("rel_glitch_level", level, 1);
    chk("rel_glitch_no_pulse", npulse - p0, 0);
    btn_in = 0;
    idx = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!level && idx < 0) idx = k;
    end
    chk("release_edge", idx, 6);
    chk("release_no_pulse", npulse - p0, 0);

    // three clean presses
    do_reset();
    p0 = npulse;
    for (int n = 0; n < 3; n++) begin
      btn_in = 1; repeat (10) tick();
      btn_in = 0; repeat (10) tick();
    end
    repeat (6) tick();
    chk("three_presses", npulse - p0, 3);

    // async reset mid-CONF_HI, then press held across release
    btn_in = 1;
    repeat (4) tick();
    #3 rst = 1'b1;
    #1;
    mreset();
    chk("rst_conf_x", x_pulse, 0);
    chk("rst_conf_level", level, 0);
    chk("rst_conf_glitch", glitch_cnt, 0);
    tick();
    rst = 1'b0;
    idx = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (x_pulse && idx < 0) idx = k;
      if (idx == k) break;
    end
    chk("post_rst_pulse_edge", idx, 6);
    chk("pulse_high_before_rst", x_pulse, 1);
    rst = 1'b1;
    #1;
    mreset();
    chk("rst_pulse_x", x_pulse, 0);
    chk("rst_pulse_level", level, 0);
    btn_in = 0;
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // 300 single-sample glitches saturate the glitch counter
    do_reset();
    for (int n = 0; n < 300; n++) begin
      btn_in = 1; tick();
      btn_in = 0; tick();
    end
    repeat (3) tick();
    chk("glitch_saturate", glitch_cnt, 255);

    // random runs, occasional reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int len;
      len = $urandom_range(1, 9);
      btn_in = $urandom_range(0, 1);
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < len; k++) begin
        tick();
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Input conditioner that sits directly upstream of the Moore sequence detector and drives its `x` input. It turns a raw, asynchronous, bouncing push-button or switch level into a clean signal. It first synchronises the raw input, then requires the level to stay stable for `DB_CYCLES` clocks. Each confirmed press produces exactly one single-cycle `x_pulse`, so every physical press advances the detector by exactly one state.

## Interface
- `DB_CYCLES`, 4, consecutive stable synchronised samples required to accept a level change; legal range 1 .. 2^`CNT_W`-1
- `CNT_W`, 8, width of the stability counter
- `GL_W`, 8, width of the glitch counter
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  reset; asynchronous, active-high; clears all state immediately
- `btn_in`  input  1  raw asynchronous button/switch level
- `x_pulse`  output  1  registered, one-cycle pulse per confirmed press (0→1); feeds detector `x`
- `level`  output  1  registered debounced level
- `glitch_cnt`  output  `GL_W`  saturating count of aborted confirmations, either direction

## Operation
- Synchroniser: two flops, `btn_in` → `s1` → `s_btn`. The FSM uses only `s_btn`.
- FSM states:
  - IDLE: `level`=0
  - CONF_HI: candidate high
  - HIGH: `level`=1
  - CONF_LO: candidate low
- Stability counter `cnt` is `CNT_W` bits wide.
- IDLE:
  - `s_btn`=1 → CONF_HI, `cnt`←0.
  - Otherwise stay.
- CONF_HI:
  - `s_btn`=0 → IDLE; `glitch_cnt`++ (saturating).
  - `s_btn`=1 and `cnt`==`DB_CYCLES`-1 → HIGH, `level`←1, `x_pulse`←1.
  - `s_btn`=1 otherwise → `cnt`++.
- HIGH:
  - `s_btn`=0 → CONF_LO, `cnt`←0.
  - Otherwise stay.
- CONF_LO:
  - `s_btn`=1 → HIGH; `glitch_cnt`++ (saturating).
  - `s_btn`=0 and `cnt`==`DB_CYCLES`-1 → IDLE, `level`←0.
  - `s_btn`=0 otherwise → `cnt`++.
- Release pulses: a release never pulses `x_pulse`.
- Pulse length: `x_pulse` is high for exactly one cycle per IDLE→HIGH path, regardless of how long the button is held.
- Glitch counter:
  - Saturates at 2^`GL_W`-1; no wrap.
  - Cleared only by `rst`.
- Counter: `cnt` never exceeds `DB_CYCLES`-1; no wrap is possible.
- Unused state encodings → IDLE on the next edge, with outputs 0.

## Timing
- Reset values:
  - state IDLE
  - `s1`, `s_btn`, `cnt` = 0
  - `x_pulse` = 0, `level` = 0, `glitch_cnt` = 0
  - All are forced asynchronously while `rst`=1.
- Press latency, with `btn_in` first sampled high at edge 0 and held:
  - `s_btn`=1 after edge 1.
  - CONF_HI after edge 2.
  - HIGH after edge `DB_CYCLES`+2.
  - `x_pulse` and `level` high in the cycle following edge `DB_CYCLES`+2. Default `DB_CYCLES`: edge 6.
  - `x_pulse` low again after edge `DB_CYCLES`+3.
- Release latency: identical count. `level` falls after edge `DB_CYCLES`+2, measured from the first low sample.
- Minimum accepted pulse: `btn_in` stable for `DB_CYCLES`+1 consecutive samples. Anything shorter is a glitch.
- Back-to-back presses: the minimum press-to-press spacing yielding two `x_pulse` is 2·(`DB_CYCLES`+1) cycles.
- Reset mid-operation: any confirmation in progress is discarded and `x_pulse` drops immediately. If `btn_in` is high at reset release, it counts as a new press, with `x_pulse` after edge `DB_CYCLES`+2 from the first post-reset edge.
- `DB_CYCLES`=1: the transition occurs on the first CONF state edge. Latency is 3 edges.

## Test plan
- Reset, then `btn_in`=0 for 20 cycles → `x_pulse`=0, `level`=0, `glitch_cnt`=0 throughout.
- `DB_CYCLES`=4; `btn_in` 0→1 sampled at edge 0, held 30 cycles → `x_pulse`=1 only after edge 6, for one cycle; `level`=1 from edge 6 onward.
- Bounce: `btn_in` high 3 cycles, low 1, high 3, low 1, then high steady → aborts counted (`glitch_cnt`=2); exactly one `x_pulse`, 6 edges after the final steady rise.
- Held press then release with a 2-cycle low glitch while in HIGH → `glitch_cnt`+1, `level` stays 1, no second `x_pulse`. A clean release drops `level` 6 edges after the first low sample.
- Three clean presses, each high 10 and low 10 cycles, feeding the downstream detector → exactly 3 `x_pulse`; detector `y` goes 1 after the third.
- `rst` asserted mid-CONF_HI and while `x_pulse`=1 → all outputs 0 asynchronously. `btn_in` held high across the reset release → one `x_pulse` after edge 6 post-release. Drive 300 glitches with `GL_W`=8 → `glitch_cnt` saturates at 255.
